// File: rtl/lane_param_calc.sv
// Lane endpoint pair -> slope m (signed Q7.FRAC_BITS) and intercept b, via a serial restoring divider.
// Results are double-buffered and committed on frame_start. Define LINE_PARAM_SMOOTH_EN for damped commits.
module lane_param_calc #(
    parameter int FRAC_BITS = 8
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic        frame_start,
    output logic [15:0] m,
    output logic [15:0] b,
    output logic        params_valid,
    output logic        div0_err,
    output logic        busy
);
    localparam int ITER = 17 + FRAC_BITS;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIV, S_ICPT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]      x0_r, y0_r, x1_r, y1_r;
    logic             neg, z;
    logic [15:0]      dvsr, rem;
    logic [ITER-1:0]  quo;
    logic [CW-1:0]    cnt;
    logic [15:0]      m_calc, b_calc;
    logic [15:0]      shadow_m, shadow_b;
    logic             shadow_z, pending;

    logic signed [16:0] dy, dx;
    logic [16:0]        dy_abs, dx_abs;
    logic [16:0]        shifted;
    logic [17:0]        diff;
    logic [15:0]        m_sat, b_sat;
    logic signed [32:0] m_ext, x_ext, prod, prod_sh;
    logic signed [33:0] y_ext, b_raw;

    assign pt_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    assign dy     = $signed({1'b0, y1_r}) - $signed({1'b0, y0_r});
    assign dx     = $signed({1'b0, x1_r}) - $signed({1'b0, x0_r});
    assign dy_abs = dy[16] ? 17'(-dy) : 17'(dy);
    assign dx_abs = dx[16] ? 17'(-dx) : 17'(dx);

    // Restoring step: remainder stays below the divisor, so 16 bits suffice.
    assign shifted = {rem, quo[ITER-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvsr};

    always_comb begin
        m_sat = 16'h7FFF;
        if (z)
            m_sat = neg ? 16'h8000 : 16'h7FFF;
        else if (!neg)
            m_sat = (quo > ITER'(32767)) ? 16'h7FFF : quo[15:0];
        else
            m_sat = (quo > ITER'(32768)) ? 16'h8000 : (~quo[15:0] + 16'd1);
    end

    assign m_ext   = {{17{m_sat[15]}}, m_sat};
    assign x_ext   = {17'd0, x0_r};
    assign prod    = m_ext * x_ext;
    assign prod_sh = prod >>> FRAC_BITS;
    assign y_ext   = {18'd0, y0_r};
    assign b_raw   = y_ext - {prod_sh[32], prod_sh};

    always_comb begin
        b_sat = b_raw[15:0];
        if (b_raw > 34'sd32767)       b_sat = 16'h7FFF;
        else if (b_raw < -34'sd32768) b_sat = 16'h8000;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pt_valid) state_nxt = S_SETUP;
            S_SETUP: state_nxt = (dx == 17'sd0) ? S_ICPT : S_DIV;
            S_DIV:   if (cnt == CW'(ITER - 1)) state_nxt = S_ICPT;
            S_ICPT:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            x0_r <= '0; y0_r <= '0; x1_r <= '0; y1_r <= '0;
            neg <= 1'b0; z <= 1'b0; dvsr <= '0; rem <= '0; quo <= '0; cnt <= '0;
            m_calc <= '0; b_calc <= '0;
        end else begin
            case (state)
                S_IDLE: if (pt_valid) begin
                    x0_r <= x0; y0_r <= y0; x1_r <= x1; y1_r <= y1;
                end
                S_SETUP: begin
                    neg  <= dy[16] ^ dx[16];
                    z    <= (dx == 17'sd0);
                    dvsr <= dx_abs[15:0];
                    quo  <= {1'b0, dy_abs[15:0], {FRAC_BITS{1'b0}}};
                    rem  <= '0;
                    cnt  <= '0;
                end
                S_DIV: begin
                    rem <= diff[17] ? shifted[15:0] : diff[15:0];
                    quo <= {quo[ITER-2:0], ~diff[17]};
                    cnt <= cnt + 1'b1;
                end
                S_ICPT: begin
                    m_calc <= m_sat;
                    b_calc <= b_sat;
                end
                default: ;
            endcase
        end
    end

    // A result finishing in the same cycle as frame_start is committed straight from DONE.
    logic        in_done, commit, c_z;
    logic [15:0] c_m, c_b, new_m, new_b;

    assign in_done = (state == S_DONE);
    assign commit  = frame_start && (pending || in_done);
    assign c_m     = in_done ? m_calc : shadow_m;
    assign c_b     = in_done ? b_calc : shadow_b;
    assign c_z     = in_done ? z      : shadow_z;

`ifdef LINE_PARAM_SMOOTH_EN
    logic signed [16:0] dm, db, sm, sb;
    always_comb begin
        dm = $signed({c_m[15], c_m}) - $signed({m[15], m});
        db = $signed({c_b[15], c_b}) - $signed({b[15], b});
        sm = $signed({m[15], m}) + (dm >>> 2);
        sb = $signed({b[15], b}) + (db >>> 2);
        new_m = (!params_valid || c_z) ? c_m : sm[15:0];
        new_b = (!params_valid || c_z) ? c_b : sb[15:0];
    end
`else
    assign new_m = c_m;
    assign new_b = c_b;
`endif

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            shadow_m <= '0; shadow_b <= '0; shadow_z <= 1'b0; pending <= 1'b0;
            m <= '0; b <= '0; params_valid <= 1'b0; div0_err <= 1'b0;
        end else begin
            if (in_done) begin
                shadow_m <= m_calc;
                shadow_b <= b_calc;
                shadow_z <= z;
                pending  <= !frame_start;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
            if (commit) begin
                m            <= new_m;
                b            <= new_b;
                div0_err     <= c_z;
                params_valid <= 1'b1;
            end
        end
    end
endmodule
